dmem_bridge: RTL

Sequential bridge between the memory stage's single-cycle SRAM-style data port and the core's SRAM-like data bus. It consumes `mem_en`/`mem_wen`/`mem_addr`/`mem_wdata`/`data_size` and returns `mem_rdata`. It converts each access into a `req`/`addr_ok`/`data_ok` transaction, stalls the pipeline until the bus completes, and holds read data until the memory stage advances. It also keeps access and stall-cycle counters for performance reporting.

---
 rtl/dmem_bridge_pkg.sv | 17 +
 rtl/dmem_bridge_perf_counter.sv | 24 ++
 rtl/dmem_bridge.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-side memory bridge: access size codes and FSM states.
package dmem_bridge_pkg;

    // Access size codes as presented by the memory stage on data_size.
    localparam logic [2:0] DSZ_BYTE = 3'd0;
    localparam logic [2:0] DSZ_HALF = 3'd1;
    localparam logic [2:0] DSZ_WORD = 3'd2;

    // Bridge transaction states, shared with the instruction-side bridge.
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } dmem_state_t;

endpackage

// File: rtl/dmem_bridge_perf_counter.sv
// Free-running event counter with enable; wraps modulo 2^CNT_W.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count one per enabled cycle; natural overflow gives the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the memory stage's single-cycle SRAM port onto a req/addr_ok/data_ok bus,
// stalling the pipeline until the bus transaction completes.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    // Memory-stage side
    input  logic             mem_en,
    input  logic [3:0]       mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [2:0]       data_size,
    output logic [31:0]      mem_rdata,
    output logic             stall,
    input  logic             pipe_advance,
    input  logic             flush,
    // Bus side
    output logic             bus_req,
    output logic             bus_wr,
    output logic [1:0]       bus_size,
    output logic [31:0]      bus_addr,
    output logic [3:0]       bus_wstrb,
    output logic [31:0]      bus_wdata,
    input  logic             bus_addr_ok,
    input  logic             bus_data_ok,
    input  logic [31:0]      bus_rdata,
    // Performance counters
    output logic [CNT_W-1:0] perf_access,
    output logic [CNT_W-1:0] perf_stall
);

    dmem_state_t state_q;
    logic        req_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        start;
    logic        complete;

    // Only the low two size bits travel on the bus.
    logic        unused_size_msb;
    assign unused_size_msb = data_size[2];

    // Accept/complete decode and the combinational stall/read-data path.
    always_comb begin
        start    = (state_q == StIdle) && mem_en && !flush;
        complete = ((state_q == StReq) && bus_addr_ok && bus_data_ok) ||
                   ((state_q == StWait) && bus_data_ok);
        stall    = start || (((state_q == StReq) || (state_q == StWait)) && !complete);
        // Bypass on the completion cycle, otherwise present the captured data.
        mem_rdata = complete ? bus_rdata : rdata_q;
    end

    // Transaction FSM with registered bus request fields; flush cannot abort a started access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        req_q   <= 1'b1;
                        wr_q    <= |mem_wen;
                        size_q  <= data_size[1:0];
                        addr_q  <= mem_addr;
                        wstrb_q <= mem_wen;
                        wdata_q <= mem_wdata;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (bus_addr_ok) begin
                        req_q <= 1'b0;
                        if (bus_data_ok) begin
                            rdata_q <= bus_rdata;
                            state_q <= pipe_advance ? StIdle : StDone;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (bus_data_ok) begin
                        rdata_q <= bus_rdata;
                        state_q <= pipe_advance ? StIdle : StDone;
                    end
                end
                StDone: begin
                    // Same instruction still sits in the memory stage; wait for it to leave.
                    if (pipe_advance || flush) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req   = req_q;
    assign bus_wr    = wr_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_access (
        .clk   (clk),
        .rst   (rst),
        .en    (complete),
        .count (perf_access)
    );

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_stall (
        .clk   (clk),
        .rst   (rst),
        .en    (stall),
        .count (perf_stall)
    );

endmodule
